// File: rtl/sort_result_checker.sv
// Run monitor: waits for the CPU to park on HALT_WORD, then scans N DMEM words and checks their order.
// Optional `SORT_CHECK_SUM_EN adds a modular sum of all scanned words compared against exp_sum.
module sort_result_checker #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 10,
    parameter int          N           = 16,
    parameter int          BASE_ADDR   = 0,
    parameter int          ADDR_STRIDE = 1,
    parameter int          DESCEND     = 0,
    parameter int          SIGNED      = 0,
    parameter int          RD_LAT      = 1,
    parameter logic [31:0] HALT_WORD   = 32'd0,
    parameter int          HALT_CYCLES = 3,
    parameter int          CNT_W       = 24,
    parameter int          TIMEOUT     = 100000,
    localparam int         IDX_W       = $clog2(N + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [31:0]       idata,
    output logic              chk_rd,
    output logic [ADDR_W-1:0] chk_addr,
    input  logic [DATA_W-1:0] chk_rdata,
    input  logic [DATA_W-1:0] exp_sum,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  err_idx,
    output logic [CNT_W-1:0]  cycles
);

    localparam int HC_W = $clog2(HALT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] BASE_A   = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_STRIDE[ADDR_W-1:0];
    localparam bit TO_REACHABLE = longint'(TIMEOUT) <= ((longint'(1) << CNT_W) - 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] N_IDX  = IDX_W'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

    state_t            state;
    logic [HC_W-1:0]   halt_cnt;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lat_cnt;
    logic [DATA_W-1:0] prev;

    logic              halt_seen;
    logic              halt_hit;
    logic [HC_W-1:0]   halt_next;
    logic [CNT_W-1:0]  cycles_next;
    logic              timeout_hit;
    logic              sample;
    logic              ordered;
    logic              sum_ok;

    assign halt_seen   = (idata == HALT_WORD);
    assign halt_next   = halt_seen ? halt_cnt + HC_W'(1) : '0;
    assign halt_hit    = halt_seen && (halt_next == HC_W'(HALT_CYCLES));
    assign cycles_next = (cycles == '1) ? cycles : cycles + CNT_W'(1);
    assign timeout_hit = TO_REACHABLE && (cycles_next == TO_VAL);
    assign sample      = (state == SCAN) && (lat_cnt == 2'(RD_LAT));

    // Equal neighbours always count as ordered in either direction.
    always_comb begin
        ordered = 1'b1;
        if (SIGNED != 0) begin
            if (DESCEND != 0) ordered = ($signed(prev) >= $signed(chk_rdata));
            else              ordered = ($signed(prev) <= $signed(chk_rdata));
        end else begin
            if (DESCEND != 0) ordered = (prev >= chk_rdata);
            else              ordered = (prev <= chk_rdata);
        end
    end

`ifdef SORT_CHECK_SUM_EN
    logic [DATA_W-1:0] sum_acc;
    logic [DATA_W-1:0] sum_next;

    assign sum_next = sum_acc + chk_rdata;
    assign sum_ok   = (sum_next == exp_sum);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sum_acc <= '0;
        end else if (state == RUN) begin
            sum_acc <= '0;
        end else if (sample) begin
            sum_acc <= sum_next;
        end
    end
`else
    logic unused_exp_sum;

    assign unused_exp_sum = ^exp_sum;
    assign sum_ok         = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            chk_rd   <= 1'b0;
            chk_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            err_idx  <= N_IDX;
            cycles   <= '0;
            halt_cnt <= '0;
            idx      <= '0;
            lat_cnt  <= '0;
            prev     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        timeout  <= 1'b0;
                        err_idx  <= N_IDX;
                        cycles   <= '0;
                        halt_cnt <= '0;
                    end
                end
                RUN: begin
                    cycles   <= cycles_next;
                    halt_cnt <= halt_next;
                    // A halt detected on the timeout cycle still gets its scan.
                    if (halt_hit) begin
                        state    <= SCAN;
                        chk_rd   <= 1'b1;
                        chk_addr <= BASE_A;
                        idx      <= '0;
                        lat_cnt  <= '0;
                    end else if (timeout_hit) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (sample) begin
                        prev <= chk_rdata;
                        if (idx != '0 && !ordered) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            chk_rd  <= 1'b0;
                            pass    <= 1'b0;
                            err_idx <= idx;
                        end else if (idx == LAST_IDX) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            chk_rd <= 1'b0;
                            pass   <= sum_ok;
                        end else begin
                            chk_rd   <= 1'b1;
                            chk_addr <= chk_addr + STRIDE_A;
                            idx      <= idx + IDX_W'(1);
                            lat_cnt  <= '0;
                        end
                    end else begin
                        chk_rd  <= 1'b0;
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_result_checker.sv
// Bench for sort_result_checker: three configurations (latency 0/1/2, asc/desc, signed/unsigned)
// checked against a cycle-level reference model of the run/scan rules.
module tb_sort_result_checker;

    localparam int NI = 3;
    localparam int N_P   [NI] = '{4, 5, 4};
    localparam int LAT_P [NI] = '{1, 2, 0};
    localparam int DS_P  [NI] = '{0, 1, 0};
    localparam int SG_P  [NI] = '{0, 1, 1};
    localparam int BASE_P[NI] = '{0, 1022, 100};
    localparam int STR_P [NI] = '{1, 3, 2};
    localparam int HC_P  [NI] = '{3, 1, 2};
    localparam int TO_P  [NI] = '{50, 1000, 100};

    typedef logic [31:0] wq_t[$];
    typedef struct {
        int total;
        int run;
        int reads;
        bit pass;
        bit tmo;
        int err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s [NI];
    logic [31:0] idata = 32'h13;
    logic [31:0] exp_sum = '0;
    logic        chk_rd  [NI];
    logic [9:0]  chk_addr[NI];
    logic [31:0] rdata   [NI];
    logic        busy    [NI];
    logic        done    [NI];
    logic        pass    [NI];
    logic        tmo     [NI];
    logic [2:0]  err_idx [NI];
    logic [23:0] cyc     [NI];

    logic [31:0] mem [NI][1024];
    logic [31:0] d1  [NI];
    logic [31:0] d2  [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model drives random garbage whenever the requested word is not yet valid.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            d1[k] <= chk_rd[k] ? mem[k][chk_addr[k]] : $urandom();
            d2[k] <= d1[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) begin
            case (LAT_P[k])
                0:       rdata[k] = chk_rd[k] ? mem[k][chk_addr[k]] : d1[k];
                1:       rdata[k] = d1[k];
                default: rdata[k] = d2[k];
            endcase
        end
    end

    sort_result_checker #(.DATA_W(32), .ADDR_W(10), .N(N_P[0]), .BASE_ADDR(BASE_P[0]),
        .ADDR_STRIDE(STR_P[0]), .DESCEND(DS_P[0]), .SIGNED(SG_P[0]), .RD_LAT(LAT_P[0]),
        .HALT_WORD(32'd0), .HALT_CYCLES(HC_P[0]), .CNT_W(24), .TIMEOUT(TO_P[0])) u_dut0 (
        .CLK(clk), .RST(rst), .start(start_s[0]), .idata(idata), .chk_rd(chk_rd[0]),
        .chk_addr(chk_addr[0]), .chk_rdata(rdata[0]), .exp_sum(exp_sum), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .timeout(tmo[0]), .err_idx(err_idx[0]), .cycles(cyc[0]));

    sort_result_checker #(.DATA_W(32), .ADDR_W(10), .N(N_P[1]), .BASE_ADDR(BASE_P[1]),
        .ADDR_STRIDE(STR_P[1]), .DESCEND(DS_P[1]), .SIGNED(SG_P[1]), .RD_LAT(LAT_P[1]),
        .HALT_WORD(32'd0), .HALT_CYCLES(HC_P[1]), .CNT_W(24), .TIMEOUT(TO_P[1])) u_dut1 (
        .CLK(clk), .RST(rst), .start(start_s[1]), .idata(idata), .chk_rd(chk_rd[1]),
        .chk_addr(chk_addr[1]), .chk_rdata(rdata[1]), .exp_sum(exp_sum), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .timeout(tmo[1]), .err_idx(err_idx[1]), .cycles(cyc[1]));

    sort_result_checker #(.DATA_W(32), .ADDR_W(10), .N(N_P[2]), .BASE_ADDR(BASE_P[2]),
        .ADDR_STRIDE(STR_P[2]), .DESCEND(DS_P[2]), .SIGNED(SG_P[2]), .RD_LAT(LAT_P[2]),
        .HALT_WORD(32'd0), .HALT_CYCLES(HC_P[2]), .CNT_W(24), .TIMEOUT(TO_P[2])) u_dut2 (
        .CLK(clk), .RST(rst), .start(start_s[2]), .idata(idata), .chk_rd(chk_rd[2]),
        .chk_addr(chk_addr[2]), .chk_rdata(rdata[2]), .exp_sum(exp_sum), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .timeout(tmo[2]), .err_idx(err_idx[2]), .cycles(cyc[2]));

    function automatic int addr_of(int id, int i);
        return (BASE_P[id] + i * STR_P[id]) % 1024;
    endfunction

    function automatic logic [31:0] true_sum(int id);
        logic [31:0] s = '0;
        for (int i = 0; i < N_P[id]; i++) s += mem[id][addr_of(id, i)];
        return s;
    endfunction

    // Reference: count RUN cycles until halt or timeout, then walk the array in index order.
    function automatic exp_t model(int id, wq_t instrs);
        exp_t        e;
        int          h;
        bit          halted;
        bit          bad;
        logic [31:0] w;
        longint      prv;
        longint      cur;
        logic [31:0] sum;
        e = '{total: 0, run: 0, reads: 0, pass: 1'b0, tmo: 1'b0, err: N_P[id]};
        h = 0; halted = 0; bad = 0; sum = '0; prv = 0;
        while (!halted && e.run < TO_P[id]) begin
            w = (e.run < instrs.size()) ? instrs[e.run] : 32'h13;
            e.run++;
            h = (w == 32'd0) ? h + 1 : 0;
            if (h == HC_P[id]) halted = 1;
        end
        if (!halted) begin
            e.tmo   = 1;
            e.total = e.run + 1;
            return e;
        end
        for (int i = 0; i < N_P[id] && !bad; i++) begin
            w   = mem[id][addr_of(id, i)];
            cur = (SG_P[id] != 0) ? longint'($signed(w)) : longint'(w);
            e.reads = i + 1;
            sum += w;
            if (i > 0 && ((DS_P[id] != 0) ? (prv < cur) : (prv > cur))) begin
                e.err = i;
                bad   = 1;
            end
            prv = cur;
        end
        e.total = e.run + e.reads * (1 + LAT_P[id]) + 1;
        if (!bad) begin
            e.pass = 1;
`ifdef SORT_CHECK_SUM_EN
            if (sum != exp_sum) begin
                e.pass = 0;
                e.err  = N_P[id];
            end
`endif
        end
        return e;
    endfunction

    task automatic set_mem(input int id, input int vals[$]);
        for (int i = 0; i < vals.size(); i++) mem[id][addr_of(id, i)] = 32'(vals[i]);
    endtask

    function automatic wq_t mk_instrs(int nz, int zeros);
        wq_t q;
        for (int i = 0; i < nz; i++) q.push_back($urandom() | 32'h1);
        for (int i = 0; i < zeros; i++) q.push_back(32'd0);
        return q;
    endfunction

    task automatic run_case(input int id, input string name, input wq_t instrs,
                            input int sum_delta, output exp_t e);
        int t;
        int rds;
        bit fin;
        exp_sum = true_sum(id) + 32'(sum_delta);
        e = model(id, instrs);
        start_s[id] = 1'b1;
        @(posedge clk); #1;
        start_s[id] = 1'b0;
        checks++;
        if (busy[id] !== 1'b1 || done[id] !== 1'b0 || err_idx[id] !== 3'(N_P[id])) begin
            errors++;
            $display("[TB] FAIL %s/start: busy=%b done=%b err_idx=%0d, expected busy=1 done=0 err_idx=%0d",
                     name, busy[id], done[id], err_idx[id], N_P[id]);
        end
        t = 1; rds = 0; fin = 0;
        while (!fin && t <= e.total + 20) begin
            idata = (t - 1 < instrs.size()) ? instrs[t - 1] : 32'h13;
            if (done[id] === 1'b1) begin
                fin = 1;
            end else begin
                if (chk_rd[id] === 1'b1) begin
                    checks++;
                    if (chk_addr[id] !== 10'(addr_of(id, rds))) begin
                        errors++;
                        $display("[TB] FAIL %s/addr%0d: got %0d, expected %0d",
                                 name, rds, chk_addr[id], addr_of(id, rds));
                    end
                    rds++;
                end
                @(posedge clk); #1;
                t++;
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("[TB] FAIL %s/done: not seen within %0d cycles", name, e.total + 20);
            return;
        end
        checks++;
        if (t !== e.total) begin
            errors++;
            $display("[TB] FAIL %s/latency: done at cycle %0d, expected %0d", name, t, e.total);
        end
        checks++;
        if (pass[id] !== e.pass || tmo[id] !== e.tmo || busy[id] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s/flags: pass=%b timeout=%b busy=%b, expected pass=%b timeout=%b busy=0",
                     name, pass[id], tmo[id], busy[id], e.pass, e.tmo);
        end
        checks++;
        if (err_idx[id] !== 3'(e.err)) begin
            errors++;
            $display("[TB] FAIL %s/err_idx: got %0d, expected %0d", name, err_idx[id], e.err);
        end
        checks++;
        if (cyc[id] !== 24'(e.run)) begin
            errors++;
            $display("[TB] FAIL %s/cycles: got %0d, expected %0d", name, cyc[id], e.run);
        end
        checks++;
        if (rds !== e.reads) begin
            errors++;
            $display("[TB] FAIL %s/reads: got %0d, expected %0d", name, rds, e.reads);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({chk_rd[k], busy[k], done[k], pass[k], tmo[k]} !== 5'b0 || chk_addr[k] !== 10'd0 ||
                err_idx[k] !== 3'(N_P[k]) || cyc[k] !== 24'd0) begin
                errors++;
                $display("[TB] FAIL reset%0d: rd/busy/done/pass/tmo=%b addr=%0d err_idx=%0d cycles=%0d, expected 0/0/%0d/0",
                         k, {chk_rd[k], busy[k], done[k], pass[k], tmo[k]}, chk_addr[k], err_idx[k], cyc[k], N_P[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        exp_t e;
        wq_t  q;
        set_mem(0, '{1, 3, 3, 9});
        run_case(0, "basic_pass", mk_instrs(10, 3), 0, e);
        checks++;
        if (cyc[0] !== 24'd13 || pass[0] !== 1'b1 || err_idx[0] !== 3'd4) begin
            errors++;
            $display("[TB] FAIL basic_const: cycles=%0d pass=%b err_idx=%0d, expected 13/1/4", cyc[0], pass[0], err_idx[0]);
        end
        set_mem(0, '{5, 2, 7, 8});
        run_case(0, "early_fail", mk_instrs(4, 3), 0, e);
        set_mem(2, '{-4, -1, 0, 2});
        run_case(2, "signed_pass", mk_instrs(3, 2), 0, e);
        set_mem(0, '{-4, -1, 0, 2});
        run_case(0, "unsigned_fail", mk_instrs(2, 3), 0, e);
        q.delete();
        run_case(0, "timeout", q, 0, e);
        q = '{32'd0, 32'd0, 32'h5, 32'd0, 32'd0, 32'd0};
        set_mem(0, '{2, 2, 2, 2});
        run_case(0, "halt_interrupt", q, 0, e);
        set_mem(1, '{30, 7, 7, -3, -40});
        run_case(1, "desc_wrap", mk_instrs(5, 1), 0, e);
        set_mem(1, '{30, 7, 8, -3, -40});
        run_case(1, "desc_fail", mk_instrs(1, 1), 0, e);
    endtask

    task automatic test_checksum();
        exp_t e;
        set_mem(0, '{1, 2, 3, 4});
        run_case(0, "sum_bad", mk_instrs(3, 3), 1, e);
        run_case(0, "sum_good", mk_instrs(3, 3), 0, e);
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        int   t;
        set_mem(0, '{1, 2, 3, 4});
        idata = 32'd0;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        t = 0;
        while (chk_rd[0] !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (chk_rd[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midscan/enter: chk_rd=%b after %0d cycles, expected 1", chk_rd[0], t);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({chk_rd[0], busy[0], done[0], pass[0], tmo[0]} !== 5'b0 || chk_addr[0] !== 10'd0 ||
                err_idx[0] !== 3'd4 || cyc[0] !== 24'd0) begin
                errors++;
                $display("[TB] FAIL midscan/reset%0d: rd/busy/done/pass/tmo=%b addr=%0d err_idx=%0d cycles=%0d, expected 0/0/4/0",
                         c, {chk_rd[0], busy[0], done[0], pass[0], tmo[0]}, chk_addr[0], err_idx[0], cyc[0]);
            end
            @(posedge clk); #1;
        end
        run_case(0, "after_reset", mk_instrs(6, 3), 0, e);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        set_mem(2, '{-9, -9, 3, 1});
        run_case(2, "b2b_first", mk_instrs(2, 2), 0, e);
        // Start mid-run of a different instance must not disturb the finished one.
        for (int c = 0; c < 4; c++) begin
            start_s[0] = (c == 0);
            idata = $urandom();
            @(posedge clk); #1;
            checks++;
            if (done[2] !== 1'b1 || pass[2] !== e.pass || err_idx[2] !== 3'(e.err) || cyc[2] !== 24'(e.run)) begin
                errors++;
                $display("[TB] FAIL b2b/hold%0d: done=%b pass=%b err_idx=%0d cycles=%0d, expected 1/%b/%0d/%0d",
                         c, done[2], pass[2], err_idx[2], cyc[2], e.pass, e.err, e.run);
            end
        end
        start_s[0] = 1'b0;
        set_mem(2, '{-9, -9, 1, 3});
        run_case(2, "b2b_second", mk_instrs(7, 2), 0, e);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        int   vals[$];
        int   v;
        int   id;
        wq_t  q;
        for (int it = 0; it < 30; it++) begin
            id = $urandom_range(0, NI - 1);
            vals.delete();
            v = (id == 0) ? $urandom_range(0, 50) : ($urandom_range(0, 60) - 30);
            for (int i = 0; i < N_P[id]; i++) begin
                vals.push_back(v);
                if (DS_P[id] != 0) v -= $urandom_range(0, 9);
                else               v += $urandom_range(0, 9);
            end
            if ($urandom_range(0, 1) == 1) vals[$urandom_range(0, N_P[id] - 1)] = int'($urandom());
            set_mem(id, vals);
            q.delete();
            for (int i = 0; i < $urandom_range(0, 12); i++)
                q.push_back(($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom() | 32'h1));
            if (!(id == 0 && $urandom_range(0, 5) == 0))
                for (int i = 0; i < HC_P[id]; i++) q.push_back(32'd0);
            run_case(id, $sformatf("rand%0d", it), q, 0, e);
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) start_s[k] = 1'b0;
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 1024; a++) mem[k][a] = $urandom();
        test_reset();
        test_directed();
        test_checksum();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
